// File: rtl/sdhci_pio_streamer.sv
// SDHCI PIO streamer: moves Buffer Data Port words
// between the host register bus and 32-bit streams.
package sdhci_pio_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module sdhci_pio_streamer #(
  parameter int unsigned          AddrWidth     = 32,
  parameter type                  reg_req_t     = sdhci_pio_pkg::reg_req_t,
  parameter type                  reg_rsp_t     = sdhci_pio_pkg::reg_rsp_t,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0,
  parameter int unsigned          PollGapCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output reg_req_t    reg_req_o,
  input  reg_rsp_t    reg_rsp_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        dir_write_i,
  input  logic [7:0]  block_words_i,
  input  logic [15:0] block_count_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] blocks_left_o
);

  localparam logic [AddrWidth-1:0] PsAddr =
    BaseAddr + AddrWidth'(32'h24);
  localparam logic [AddrWidth-1:0] DpAddr =
    BaseAddr + AddrWidth'(32'h20);
  localparam logic [15:0] GapLast =
    16'(PollGapCycles - 1);

  typedef enum logic [3:0] {
    IDLE,
    GAP,
    POLL,
    XFER_RD,
    PUSH,
    PULL,
    XFER_WR,
    DONE,
    ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  words_q, words_d;
  logic [7:0]  bw_q, bw_d;
  logic [15:0] blocks_q, blocks_d;
  logic        dir_q, dir_d;
  logic [31:0] data_q, data_d;
  logic        error_q, error_d;
  logic        abort_q, abort_d;
  logic        hold_q, hold_d;

  logic        bus_state;
  logic        req_valid;
  logic        bus_hs;
  logic        bus_err;
  logic        abort_any;
  logic        blk_end;
  logic        buf_en;

  // Bus request is a pure decode of the registered state.
  always_comb begin
    bus_state = (state_q == POLL) ||
                (state_q == XFER_RD) ||
                (state_q == XFER_WR);
    req_valid = bus_state && !hold_q;
    bus_hs    = req_valid && reg_rsp_i.ready;
    bus_err   = bus_hs && reg_rsp_i.error;
    abort_any = abort_q || abort_i;
    buf_en    = dir_q ? reg_rsp_i.rdata[10]
                      : reg_rsp_i.rdata[11];
  end

  // Register-bus request fields.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.valid = req_valid;
    reg_req_o.addr  = (state_q == POLL) ? PsAddr
                                        : DpAddr;
    reg_req_o.write = (state_q == XFER_WR);
    reg_req_o.wdata = data_q;
    reg_req_o.wstrb = 4'hF;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    words_d  = words_q;
    bw_d     = bw_q;
    blocks_d = blocks_q;
    dir_d    = dir_q;
    data_d   = data_q;
    error_d  = error_q;
    abort_d  = abort_q || abort_i;
    hold_d   = 1'b0;
    blk_end  = 1'b0;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          dir_d    = dir_write_i;
          bw_d     = block_words_i;
          blocks_d = block_count_i;
          error_d  = 1'b0;
          gap_d    = '0;
          if (block_words_i == 8'd0 ||
              block_count_i == 16'd0) begin
            state_d = ERROR;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (abort_any) begin
          state_d = ERROR;
        end else if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = POLL;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      POLL: begin
        if (bus_hs) begin
          if (bus_err || abort_any) begin
            state_d = ERROR;
          end else if (buf_en) begin
            words_d = bw_q;
            if (dir_q) begin
              state_d = PULL;
            end else begin
              state_d = XFER_RD;
              hold_d  = 1'b1;
            end
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      XFER_RD: begin
        if (bus_hs) begin
          data_d = reg_rsp_i.rdata;
          if (bus_err || abort_any) begin
            state_d = ERROR;
          end else begin
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        if (abort_q) begin
          state_d = ERROR;
        end else if (rd_ready_i) begin
          words_d = words_q - 8'd1;
          if (words_q == 8'd1) begin
            blk_end = 1'b1;
          end else if (abort_i) begin
            state_d = ERROR;
          end else begin
            state_d = XFER_RD;
          end
        end
      end
      PULL: begin
        if (abort_q) begin
          state_d = ERROR;
        end else if (wr_valid_i) begin
          data_d  = wr_data_i;
          state_d = XFER_WR;
        end
      end
      XFER_WR: begin
        if (bus_hs) begin
          if (bus_err) begin
            state_d = ERROR;
          end else begin
            words_d = words_q - 8'd1;
            if (words_q == 8'd1) begin
              blk_end = 1'b1;
            end else if (abort_any) begin
              state_d = ERROR;
            end else begin
              state_d = PULL;
            end
          end
        end
      end
      DONE: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      ERROR: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (blk_end) begin
      blocks_d = blocks_q - 16'd1;
      if (blocks_q == 16'd1) begin
        state_d = DONE;
      end else if (abort_any) begin
        state_d = ERROR;
      end else begin
        gap_d   = '0;
        state_d = GAP;
      end
    end

    if (state_d == ERROR) begin
      error_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      words_q  <= '0;
      bw_q     <= '0;
      blocks_q <= '0;
      dir_q    <= 1'b0;
      data_q   <= '0;
      error_q  <= 1'b0;
      abort_q  <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      words_q  <= words_d;
      bw_q     <= bw_d;
      blocks_q <= blocks_d;
      dir_q    <= dir_d;
      data_q   <= data_d;
      error_q  <= error_d;
      abort_q  <= abort_d;
      hold_q   <= hold_d;
    end
  end

  // Stream and status outputs.
  always_comb begin
    rd_data_o     = data_q;
    rd_valid_o    = (state_q == PUSH) && !abort_q;
    wr_ready_o    = (state_q == PULL) && !abort_q;
    busy_o        = (state_q != IDLE) &&
                    (state_q != DONE) &&
                    (state_q != ERROR);
    done_o        = (state_q == DONE);
    error_o       = error_q;
    blocks_left_o = blocks_q;
  end

endmodule
